// File: rtl/fifo_pkg.sv
// Shared defaults and status bundle for the flexible synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned DefWordLength     = 8;
  localparam int unsigned DefAddrBits       = 3;
  localparam int unsigned DefAlmostFullThr  = 6;
  localparam int unsigned DefAlmostEmptyThr = 2;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flex_ctrl.sv
// FIFO control: wrap-bit pointers, occupancy, threshold flags and sticky error flags.
module fifo_flex_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AddrBits       = DefAddrBits,
  parameter int unsigned AlmostFullThr  = DefAlmostFullThr,
  parameter int unsigned AlmostEmptyThr = DefAlmostEmptyThr
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_i,
  input  logic                rd_i,
  input  logic                flush_i,
  input  logic                clr_err_i,
  output logic                we_o,
  output logic [AddrBits-1:0] waddr_o,
  output logic [AddrBits-1:0] raddr_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                almost_empty_o,
  output logic                almost_full_o,
  output logic [AddrBits:0]   count_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int unsigned PtrW = AddrBits + 1;
  localparam logic [AddrBits:0] AfThr = PtrW'(AlmostFullThr);
  localparam logic [AddrBits:0] AeThr = PtrW'(AlmostEmptyThr);

  logic [AddrBits:0] wptr_q, rptr_q;
  logic              overflow_q, underflow_q;
  logic              empty, full;
  logic              rd_acc, wr_acc, ovf_evt, unf_evt;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrBits-1:0] == rptr_q[AddrBits-1:0]) &&
                   (wptr_q[AddrBits] != rptr_q[AddrBits]);
  assign count_o = wptr_q - rptr_q;

  // A read frees a slot in the same cycle, so write-at-full succeeds when paired with a read.
  always_comb begin
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!flush_i) begin
      rd_acc  = rd_i && !empty;
      wr_acc  = wr_i && (!full || rd_acc);
      ovf_evt = wr_i && !wr_acc;
      unf_evt = rd_i && empty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (flush_i) begin
        rptr_q <= wptr_q;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + 1'b1;
        if (rd_acc) rptr_q <= rptr_q + 1'b1;
      end
      // A new error event outranks a concurrent clear.
      overflow_q  <= ovf_evt || (overflow_q  && !clr_err_i);
      underflow_q <= unf_evt || (underflow_q && !clr_err_i);
    end
  end

  assign we_o           = wr_acc;
  assign waddr_o        = wptr_q[AddrBits-1:0];
  assign raddr_o        = rptr_q[AddrBits-1:0];
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_empty_o = (count_o <= AeThr);
  assign almost_full_o  = (count_o >= AfThr);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/fifo_flex_regfile.sv
// Simple dual-port register file: one synchronous write port, one asynchronous read port.
module fifo_flex_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned WordLength = DefWordLength,
  parameter int unsigned AddrBits   = DefAddrBits
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrBits-1:0]   waddr_i,
  input  logic [WordLength-1:0] wdata_i,
  input  logic [AddrBits-1:0]   raddr_i,
  output logic [WordLength-1:0] rdata_o
);

  logic [WordLength-1:0] mem [2**AddrBits];

  // Contents are intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// First-word-fall-through synchronous FIFO with occupancy, threshold and sticky error flags.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WordLength     = DefWordLength,
  parameter int unsigned AddrBits       = DefAddrBits,
  parameter int unsigned AlmostFullThr  = DefAlmostFullThr,
  parameter int unsigned AlmostEmptyThr = DefAlmostEmptyThr
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic [WordLength-1:0] w_data_i,
  input  logic                  rd_i,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  output logic [WordLength-1:0] r_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [AddrBits:0]     count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  logic                we;
  logic [AddrBits-1:0] waddr, raddr;

  fifo_flex_ctrl #(
    .AddrBits       (AddrBits),
    .AlmostFullThr  (AlmostFullThr),
    .AlmostEmptyThr (AlmostEmptyThr)
  ) u_ctrl (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_i           (wr_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .clr_err_i      (clr_err_i),
    .we_o           (we),
    .waddr_o        (waddr),
    .raddr_o        (raddr),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_empty_o (almost_empty_o),
    .almost_full_o  (almost_full_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  fifo_flex_regfile #(
    .WordLength (WordLength),
    .AddrBits   (AddrBits)
  ) u_regfile (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (w_data_i),
    .raddr_i (raddr),
    .rdata_o (r_data_o)
  );

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised successor to the team's basic synchronous FIFO.
- Adds the following on top of the plain full/empty buffer:
  - occupancy count
  - programmable almost-full/almost-empty flags
  - sticky overflow/underflow error flags
  - synchronous flush
  - defined simultaneous read/write behaviour at full and empty
- Used as the general-purpose elastic buffer between streaming datapath stages.
- Read data is first-word-fall-through (head word always visible on r_data_o).

Parameters:
- WordLength, 8, data width in bits (>=1).
- AddrBits, 3, address width; depth = 2^AddrBits (>=1).
- AlmostFullThr, 6, almost_full_o asserted when count >= this (1..depth).
- AlmostEmptyThr, 2, almost_empty_o asserted when count <= this (0..depth-1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, synchronous, active-low
- wr_i  in  1  write request
- w_data_i  in  WordLength  write data
- rd_i  in  1  read request (pops head word)
- flush_i  in  1  synchronous flush, empties FIFO
- clr_err_i  in  1  clears sticky error flags
- r_data_o  out  WordLength  head word (FWFT, valid while empty_o=0)
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- almost_empty_o  out  1  count <= AlmostEmptyThr
- almost_full_o  out  1  count >= AlmostFullThr
- count_o  out  AddrBits+1  current occupancy, 0..2^AddrBits
- overflow_o  out  1  sticky: write attempted while full and not accepted
- underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-low, named rst_ni.
- All state updates on the rising edge of clk_i.
- Reset (rst_ni=0 at an edge), which has highest priority:
  - write/read pointers = 0, count_o = 0
  - empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0 (AlmostFullThr>=1)
  - overflow_o = 0, underflow_o = 0
  - Storage contents are not reset; r_data_o is don't-care while empty_o=1.
- Reset mid-stream discards all contents; the first write after reset lands at address 0.
- Pointers:
  - AddrBits+1 bits each; the MSB is the wrap bit; storage address = low AddrBits bits.
  - empty = (wptr == rptr).
  - full = (low bits equal) and (MSBs differ).
  - count_o = wptr - rptr, modulo 2^(AddrBits+1).
  - Wrap-around is natural modulo increment.
- Write accepted iff wr_i and (not full, or rd_i accepted in the same cycle).
  - Data written at wptr on the edge; wptr increments.
- Read accepted iff rd_i and not empty. rptr increments on the edge.
- Latency:
  - A word written at edge N appears on r_data_o after edge N when the FIFO was empty.
  - empty_o deasserts in the same cycle the word appears; zero-bubble FWFT.
- r_data_o = storage[rptr] (combinational from the registered pointer).
- Simultaneous read and write:
  - Full and rd_i&wr_i: both accepted; count unchanged; full_o stays 1; no overflow.
  - Empty and rd_i&wr_i: write accepted, read rejected; underflow_o set; count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Error flags:
  - overflow_o set on an edge where wr_i=1 and the write is rejected.
  - underflow_o set on an edge where rd_i=1 and empty.
  - Both hold until clr_err_i=1 or reset.
  - If clr_err_i and a new error event coincide, the set wins (flag=1).
- flush_i=1:
  - rptr <= wptr; wr_i and rd_i in that cycle are ignored.
  - Count becomes 0 next cycle; no error flags are set by that cycle's requests.
  - Error flags are not cleared by flush.
- Flag outputs (empty/full/almost/count) are all functions of registered pointers, so they are glitch-free and valid one edge after the causing event.
- Priority: reset > flush > read/write.

Decomposition:
- Package fifo_pkg holds:
  - default constants for WordLength, AddrBits and the thresholds
  - a packed struct fifo_status_t {empty, full, almost_empty, almost_full, overflow, underflow} for consumers that bundle status.
- Sub-module fifo_flex_ctrl holds the pointers, count, flags and error logic.
- The existing register file is instantiated for storage, with write enable = accepted write.
- The top level only wires the two together.

Test Plan (AddrBits=3, depth 8, AlmostFullThr=6, AlmostEmptyThr=2, WordLength=8):
1. Reset, then write 0x01..0x08 on 8 consecutive cycles -> count_o 1..8; almost_empty_o drops when count=3; almost_full_o rises when count=6; full_o=1 at count 8; overflow_o=0.
2. From full, write 0xAA alone -> rejected, count_o stays 8, overflow_o=1 and held; then pulse clr_err_i -> overflow_o=0.
3. From full, rd_i&wr_i with 0x55 for 8 cycles -> r_data_o reads 0x01..0x08 in order, count_o=8 throughout; drain then yields eight 0x55 words (pointer wrap verified).
4. From empty, rd_i&wr_i with 0x3C -> count_o=1, underflow_o=1, r_data_o=0x3C with empty_o=0 the next cycle.
5. Fill with 5 words, assert flush_i together with wr_i -> count_o=0, empty_o=1, no word written, error flags unchanged.
6. Fill with 4 words, assert rst_ni=0 for one edge -> all outputs at reset values; next write of 0x77 appears on r_data_o with count_o=1.
